// File: rtl/dll_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dll_ctrl_pkg
// Shared definitions for the DLL control blocks: the lock-sequencer state
// encoding, the counter widths and a saturating increment for the retry count.
// ----------------------------------------------------------------------------
package dll_ctrl_pkg;

    localparam int TO_CNT_W  = 16;  // WAIT_LOCK timeout counter width
    localparam int CYC_CNT_W = 8;   // reset-pulse / stability cycle counter width
    localparam int RETRY_W   = 4;   // retry counter width

    // Encoding is visible on the STATE port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSERT_RST = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_STABLE     = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAIL       = 3'd5
    } dll_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] cnt);
        return (cnt == {RETRY_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dll_sync2.sv
// ----------------------------------------------------------------------------
// dll_sync2
// Two-flop synchronizer for asynchronous DLL status bits, one independent
// chain per bit.
//   clkin_ps  : destination clock
//   rst_reg   : asynchronous active-high reset, clears both flop stages
//   async_in  : asynchronous status input(s)
//   sync_out  : synchronized output(s), two cycles of latency
// ----------------------------------------------------------------------------
module dll_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clkin_ps,
    input  logic             rst_reg,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clkin_ps or posedge rst_reg) begin
                if (rst_reg) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_out[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/dll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// dll_lock_sequencer
// Drives the DLL reset, waits for LOCKED, qualifies it as stable and then
// reports READY. Failed attempts (timeout in WAIT_LOCK or lock lost in RUN)
// restart the reset pulse until MAX_RETRIES is used up, after which the block
// parks in FAIL until enable drops.
//   clkin_ps  : free-running clock
//   rst_reg   : asynchronous active-high reset
//   enable    : request a lock sequence; low forces IDLE
//   locked_in : DLL LOCKED (asynchronous)
//   dll_rst   : DLL reset drive (registered)
//   ready     : locked and stable
//   lock_lost : sticky, lock dropped while ready
//   fail      : retries exhausted
//   retry_cnt : failed attempts since IDLE (saturating)
//   state     : current state encoding
// ----------------------------------------------------------------------------
module dll_lock_sequencer
    import dll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 3,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic               clkin_ps,
    input  logic               rst_reg,
    input  logic               enable,
    input  logic               locked_in,
    output logic               dll_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    // Down-counters are loaded with N-1 so that a zero compare marks the
    // last cycle of an N-cycle interval.
    localparam logic [CYC_CNT_W-1:0] RST_LOAD   = CYC_CNT_W'(RST_CYCLES - 1);
    localparam logic [CYC_CNT_W-1:0] STB_LOAD   = CYC_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_CNT_W-1:0]  TO_LAST    = TO_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIM  = RETRY_W'(MAX_RETRIES);

    dll_state_t           state_reg;
    logic                 dll_rst_reg;
    logic                 ready_reg;
    logic                 lock_lost_reg;
    logic                 fail_reg;
    logic [RETRY_W-1:0]   retry_reg;
    logic [CYC_CNT_W-1:0] cyc_reg;
    logic [TO_CNT_W-1:0]  to_reg;

    logic lk;
    logic timeout_hit;
    logic attempt_fail;
    logic retry_ok;

    dll_sync2 #(.WIDTH(1)) u_lock_sync (
        .clkin_ps (clkin_ps),
        .rst_reg  (rst_reg),
        .async_in (locked_in),
        .sync_out (lk)
    );

    // A timeout only counts when lk is still low, so a simultaneous lock
    // wins and the WAIT_LOCK branch below moves to STABLE instead.
    assign timeout_hit  = (state_reg == ST_WAIT_LOCK) && !lk && (to_reg == TO_LAST);
    assign attempt_fail = timeout_hit || ((state_reg == ST_RUN) && !lk);
    assign retry_ok     = (retry_reg < RETRY_LIM);

    always_ff @(posedge clkin_ps or posedge rst_reg) begin
        if (rst_reg) begin
            state_reg     <= ST_IDLE;
            dll_rst_reg   <= 1'b1;
            ready_reg     <= 1'b0;
            lock_lost_reg <= 1'b0;
            fail_reg      <= 1'b0;
            retry_reg     <= '0;
            cyc_reg       <= '0;
            to_reg        <= '0;
        end else if (!enable) begin
            state_reg     <= ST_IDLE;
            dll_rst_reg   <= 1'b1;
            ready_reg     <= 1'b0;
            lock_lost_reg <= 1'b0;
            fail_reg      <= 1'b0;
            retry_reg     <= '0;
        end else if (attempt_fail) begin
            dll_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            if (state_reg == ST_RUN) begin
                lock_lost_reg <= 1'b1;
            end
            if (retry_ok) begin
                state_reg <= ST_ASSERT_RST;
                cyc_reg   <= RST_LOAD;
                retry_reg <= retry_sat_inc(retry_reg);
            end else begin
                state_reg <= ST_FAIL;
                fail_reg  <= 1'b1;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg   <= ST_ASSERT_RST;
                    cyc_reg     <= RST_LOAD;
                    dll_rst_reg <= 1'b1;
                end
                ST_ASSERT_RST: begin
                    if (cyc_reg == '0) begin
                        state_reg   <= ST_WAIT_LOCK;
                        dll_rst_reg <= 1'b0;
                        to_reg      <= '0;
                    end else begin
                        cyc_reg <= cyc_reg - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk) begin
                        state_reg <= ST_STABLE;
                        cyc_reg   <= STB_LOAD;
                    end else begin
                        to_reg <= to_reg + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // Falling back keeps to_reg, so bouncing lock cannot
                    // extend the overall timeout window.
                    if (!lk) begin
                        state_reg <= ST_WAIT_LOCK;
                    end else if (cyc_reg == '0) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end else begin
                        cyc_reg <= cyc_reg - 1'b1;
                    end
                end
                ST_RUN, ST_FAIL: begin
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    dll_rst_reg   <= 1'b1;
                    ready_reg     <= 1'b0;
                    lock_lost_reg <= 1'b0;
                    fail_reg      <= 1'b0;
                    retry_reg     <= '0;
                end
            endcase
        end
    end

    assign dll_rst   = dll_rst_reg;
    assign ready     = ready_reg;
    assign lock_lost = lock_lost_reg;
    assign fail      = fail_reg;
    assign retry_cnt = retry_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_dll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dll_lock_sequencer
// Two sequencer instances share one set of inputs: u_a with long timeout and
// default retries, u_b with a 16-cycle timeout and two retries. A reference
// model tracks both every cycle; a vector table and hand sequences cover the
// specific corner cases.
// ----------------------------------------------------------------------------
module tb_dll_lock_sequencer;

    localparam int RSTC  = 3;
    localparam int STB   = 4;
    localparam int TO_A  = 1024;
    localparam int MAX_A = 7;
    localparam int TO_B  = 16;
    localparam int MAX_B = 2;

    localparam int P_IDLE   = 0;
    localparam int P_ASSERT = 1;
    localparam int P_WAIT   = 2;
    localparam int P_STABLE = 3;
    localparam int P_RUN    = 4;
    localparam int P_FAIL   = 5;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic enable    = 1'b0;
    logic locked_in = 1'b0;

    logic       dll_rst_a, ready_a, lost_a, fail_a;
    logic [3:0] retry_a;
    logic [2:0] state_a;
    logic       dll_rst_b, ready_b, lost_b, fail_b;
    logic [3:0] retry_b;
    logic [2:0] state_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dll_lock_sequencer #(
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO_A), .STABLE_CYCLES(STB), .MAX_RETRIES(MAX_A)
    ) u_a (
        .clkin_ps(clk), .rst_reg(rst), .enable(enable), .locked_in(locked_in),
        .dll_rst(dll_rst_a), .ready(ready_a), .lock_lost(lost_a), .fail(fail_a),
        .retry_cnt(retry_a), .state(state_a)
    );

    dll_lock_sequencer #(
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO_B), .STABLE_CYCLES(STB), .MAX_RETRIES(MAX_B)
    ) u_b (
        .clkin_ps(clk), .rst_reg(rst), .enable(enable), .locked_in(locked_in),
        .dll_rst(dll_rst_b), .ready(ready_b), .lock_lost(lost_b), .fail(fail_b),
        .retry_cnt(retry_b), .state(state_b)
    );

    // ------------------------------------------------------------------
    // Reference model: phase plus elapsed-cycle counts, outputs derived
    // from the phase.
    // ------------------------------------------------------------------
    typedef struct {
        int phase;
        int rst_done;
        int wait_elapsed;
        int stable_seen;
        int retries;
        bit lost;
    } mdl_t;

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};
    bit   lkq[$] = '{1'b0, 1'b0};   // locked_in seen two edges late
    bit   lk_now;

    function automatic mdl_t count_attempt(mdl_t m, int max_r);
        mdl_t n = m;
        if (n.retries < max_r) begin
            n.retries  = (n.retries < 15) ? n.retries + 1 : 15;
            n.phase    = P_ASSERT;
            n.rst_done = 0;
        end else begin
            n.phase = P_FAIL;
        end
        return n;
    endfunction

    function automatic mdl_t model_step(mdl_t m, bit en, bit lk, int to_lim, int max_r);
        mdl_t n = m;
        if (!en) begin
            n.phase   = P_IDLE;
            n.retries = 0;
            n.lost    = 1'b0;
            return n;
        end
        case (m.phase)
            P_IDLE: begin
                n.phase    = P_ASSERT;
                n.rst_done = 0;
            end
            P_ASSERT: begin
                n.rst_done = m.rst_done + 1;
                if (n.rst_done == RSTC) begin
                    n.phase        = P_WAIT;
                    n.wait_elapsed = 0;
                end
            end
            P_WAIT: begin
                if (lk) begin
                    n.phase       = P_STABLE;
                    n.stable_seen = 0;
                end else begin
                    n.wait_elapsed = m.wait_elapsed + 1;
                    if (n.wait_elapsed == to_lim) n = count_attempt(n, max_r);
                end
            end
            P_STABLE: begin
                if (!lk) begin
                    n.phase = P_WAIT;
                end else begin
                    n.stable_seen = m.stable_seen + 1;
                    if (n.stable_seen == STB) n.phase = P_RUN;
                end
            end
            P_RUN: begin
                if (!lk) begin
                    n.lost = 1'b1;
                    n = count_attempt(n, max_r);
                end
            end
            default: begin
            end
        endcase
        return n;
    endfunction

    function automatic logic [10:0] model_vec(mdl_t m);
        logic drst;
        drst = (m.phase == P_IDLE) || (m.phase == P_ASSERT) || (m.phase == P_FAIL);
        return {3'(m.phase), drst, (m.phase == P_RUN), m.lost, (m.phase == P_FAIL), 4'(m.retries)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma  = '{default: 0};
            mb  = '{default: 0};
            lkq = '{1'b0, 1'b0};
        end else begin
            lk_now = lkq.pop_front();
            lkq.push_back(locked_in);
            ma = model_step(ma, enable, lk_now, TO_A, MAX_A);
            mb = model_step(mb, enable, lk_now, TO_B, MAX_B);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            if (err_cnt <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            check("model_a",
                  32'({state_a, dll_rst_a, ready_a, lost_a, fail_a, retry_a}), 32'(model_vec(ma)));
            check("model_b",
                  32'({state_b, dll_rst_b, ready_b, lost_b, fail_b, retry_b}), 32'(model_vec(mb)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        enable    = 1'b0;
        locked_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) at negedges for a state on u_a (use_b=0) or u_b.
    task automatic wait_state(input bit use_b, input logic [2:0] st, input int budget,
                              input string name);
        int n;
        n = 0;
        while (((use_b ? state_b : state_a) !== st) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(use_b ? state_b : state_a), 32'(st));
    endtask

    typedef struct {
        logic       en;
        logic       lk;
        logic [2:0] st;
        logic       drst;
        logic       rdy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n;
        int pulses;
        int ns;
        logic [2:0] prev;
        int rate;

        tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0};

        fork
            monitor_loop();
        join_none

        // Reset values while rst is held.
        @(negedge clk);
        check("reset_state_a",
              32'({state_a, dll_rst_a, ready_a, lost_a, fail_a, retry_a}), 32'(11'b000_1_0_0_0_0000));

        // Vector table on u_a.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            enable    = tbl[i].en;
            locked_in = tbl[i].lk;
            @(negedge clk);
            check($sformatf("table[%0d]", i),
                  32'({state_a, dll_rst_a, ready_a, fail_a}),
                  32'({tbl[i].st, tbl[i].drst, tbl[i].rdy, 1'b0}));
        end

        // Reset pulse length and READY latency after lock.
        do_reset();
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dll_rst_a) n++;
            else break;
        end
        check("rst_pulse_len", 32'(n), 32'(RSTC));
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 50) locked_in = 1'b1;
        end
        check($sformatf("ready_latency_%0d", n), 32'(n >= 55 && n <= 57), 32'd1);
        check("ready_retry", 32'(retry_a), 32'd0);

        // Retries exhausted on u_b, then release via enable.
        do_reset();
        enable = 1'b1;
        pulses = 0;
        prev   = 3'd0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (state_b == 3'd1 && prev != 3'd1) pulses++;
            prev = state_b;
            if (state_b == 3'd5) break;
        end
        check("fail_pulses", 32'(pulses), 32'd3);
        check("fail_outputs", 32'({fail_b, dll_rst_b, ready_b, retry_b}), 32'({1'b1, 1'b1, 1'b0, 4'd2}));
        enable = 1'b0;
        @(negedge clk);
        check("fail_release", 32'({state_b, fail_b}), 32'({3'd0, 1'b0}));

        // Lock lost in RUN on u_a.
        do_reset();
        locked_in = 1'b1;
        enable    = 1'b1;
        wait_state(1'b0, 3'd4, 40, "reach_run");
        check("run_ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        locked_in = 1'b0;
        @(negedge clk);
        locked_in = 1'b1;
        n = 0;
        while (ready_a !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("lost_outputs", 32'({lost_a, ready_a, retry_a, state_a, dll_rst_a}),
              32'({1'b1, 1'b0, 4'd1, 3'd1, 1'b1}));
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dll_rst_a) n++;
            else break;
        end
        check("relock_pulse_len", 32'(n), 32'(RSTC));
        n = 0;
        while (ready_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lost_sticky", 32'({ready_a, lost_a}), 32'({1'b1, 1'b1}));

        // One-cycle glitch during STABLE on u_a.
        do_reset();
        locked_in = 1'b1;
        enable    = 1'b1;
        wait_state(1'b0, 3'd3, 20, "reach_stable");
        locked_in = 1'b0;
        @(negedge clk);
        locked_in = 1'b1;
        wait_state(1'b0, 3'd2, 10, "glitch_back_to_wait");
        ns = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state_a == 3'd3) ns++;
            if (ready_a) break;
        end
        check("glitch_stable_cycles", 32'(ns), 32'(STB));

        // Asynchronous reset pulse mid-cycle during WAIT_LOCK.
        do_reset();
        enable = 1'b1;
        wait_state(1'b0, 3'd2, 20, "reach_wait");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_reset_a",
              32'({state_a, dll_rst_a, ready_a, lost_a, fail_a, retry_a}), 32'(11'b000_1_0_0_0_0000));
        check("async_reset_b",
              32'({state_b, dll_rst_b, ready_b, lost_b, fail_b, retry_b}), 32'(11'b000_1_0_0_0_0000));
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_async_reset", 32'(state_a), 32'd1);
        wait_state(1'b0, 3'd2, 10, "rewait_after_reset");

        // Enable drop on the timeout cycle of u_b.
        do_reset();
        enable = 1'b1;
        wait_state(1'b1, 3'd2, 20, "b_reach_wait");
        repeat (TO_B - 1) @(negedge clk);
        check("to_boundary_wait", 32'(state_b), 32'd2);
        enable = 1'b0;
        @(negedge clk);
        check("enable_beats_timeout", 32'({state_b, retry_b}), 32'({3'd0, 4'd0}));

        // Randomized run against the model.
        do_reset();
        enable = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            rate = $urandom_range(3, 40);
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if ($urandom_range(0, rate - 1) == 0) locked_in = ~locked_in;
                enable = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 299) == 0) begin
                    #1 rst = 1'b1;
                    #1 rst = 1'b0;
                end
            end
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dll_lock_sequencer.md
DLL_LOCK_SEQUENCER -- requirements
Module: dll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 3, SHALL set the number of CLKIN cycles DLL_RST is held high; legal range 3..255.
REQ-002 Parameter LOCK_TIMEOUT, default 1024, SHALL set the maximum cycles spent in WAIT_LOCK; legal range 16..65535.
REQ-003 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive synchronized-high cycles of LOCKED_IN required before READY; legal range 1..255.
REQ-004 Parameter MAX_RETRIES, default 7, SHALL set the number of failed lock attempts tolerated before FAIL; legal range 0..15.
REQ-005 CLKIN  input  1  SHALL be the single free-running clock; all logic is clocked on its rising edge.
REQ-006 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 ENABLE  input  1  SHALL request a lock sequence when high; low forces IDLE.
REQ-008 LOCKED_IN  input  1  SHALL carry the DLL LOCKED output, treated as asynchronous.
REQ-009 DLL_RST  output  1  SHALL drive the DLL RST input.
REQ-010 READY  output  1  SHALL indicate the DLL is locked and stable.
REQ-011 LOCK_LOST  output  1  SHALL be a sticky flag set when lock drops while READY; cleared only by RST or ENABLE low.
REQ-012 FAIL  output  1  SHALL indicate that retries are exhausted.
REQ-013 RETRY_CNT  output  4  SHALL report failed attempts since the last IDLE.
REQ-014 STATE  output  3  SHALL expose the current state encoding.

Function
REQ-015 LOCKED_IN SHALL pass through a 2-flop synchronizer; "lk" below means the synchronizer output, which has 2 cycles of latency.
REQ-016 The state encoding SHALL be IDLE=0, ASSERT_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-017 IDLE: DLL_RST=1, RETRY_CNT cleared, LOCK_LOST cleared; if ENABLE=1, go to ASSERT_RST next cycle.
REQ-018 ASSERT_RST: DLL_RST=1 for exactly RST_CYCLES cycles, counted by a cycle counter loaded on entry; then go to WAIT_LOCK.
REQ-019 WAIT_LOCK: DLL_RST=0; if lk=1, go to STABLE; if LOCK_TIMEOUT cycles elapse with lk=0, count an attempt (REQ-022).
REQ-020 STABLE: if lk stays 1 for STABLE_CYCLES consecutive cycles, go to RUN; if lk=0 on any cycle, return to WAIT_LOCK without resetting the timeout counter.
REQ-021 RUN: READY=1 (registered, asserted on the first RUN cycle); if lk=0, set LOCK_LOST, deassert READY on the same edge, and count an attempt.
REQ-022 Counting an attempt: if RETRY_CNT < MAX_RETRIES, increment RETRY_CNT and go to ASSERT_RST; otherwise go to FAIL.
REQ-023 FAIL: FAIL=1, DLL_RST=1, READY=0; stay until ENABLE=0, then go to IDLE.
REQ-024 ENABLE=0 in any state SHALL force IDLE on the next edge, with priority over every other transition.
REQ-025 A timeout and lk rising on the same cycle SHALL resolve in favour of lk (go to STABLE).
REQ-026 RETRY_CNT SHALL saturate at 15 and never wrap.
REQ-027 All outputs SHALL be registered; DLL_RST SHALL be glitch-free.

Reset
REQ-028 While RST=1: state=IDLE, DLL_RST=1, READY=0, LOCK_LOST=0, FAIL=0, RETRY_CNT=0, all counters and synchronizer flops=0.
REQ-029 RST asserted mid-sequence SHALL take effect immediately and asynchronously; after release, the block restarts from IDLE.

Structure
REQ-030 A shared package dll_ctrl_pkg SHALL hold the state typedef/encoding and the counter width constants (16-bit timeout counter, 8-bit cycle counter).
REQ-031 The synchronizer SHALL be a separate sub-module, dll_sync2, reused for any asynchronous DLL status bit.

Verification
REQ-032 RST released, ENABLE=1, LOCKED_IN rises 50 cycles after DLL_RST falls -> DLL_RST high for exactly 3 cycles after IDLE exit; READY at fall+50+2+4 cycles (±1); RETRY_CNT=0.
REQ-033 LOCKED_IN held 0, MAX_RETRIES=2, LOCK_TIMEOUT=16 -> three ASSERT_RST pulses, RETRY_CNT=2, then FAIL=1 and DLL_RST=1; ENABLE=0 -> IDLE with FAIL=0.
REQ-034 In RUN, LOCKED_IN drops for 1 cycle -> LOCK_LOST=1, READY=0, RETRY_CNT=1, new 3-cycle DLL_RST pulse; LOCK_LOST stays 1 after relock.
REQ-035 LOCKED_IN glitches 0 during STABLE with STABLE_CYCLES=4 -> return to WAIT_LOCK, READY delayed until 4 clean cycles.
REQ-036 RST pulsed asynchronously (mid-cycle) during WAIT_LOCK -> all outputs take reset values without a clock edge; normal sequence follows release.
REQ-037 ENABLE=0 on the same cycle as a WAIT_LOCK timeout -> next state IDLE, RETRY_CNT=0.
